// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the UART configuration-frame controller.
//   frame_state_t  : parser FSM state encoding
//   DEF_HDR0/1     : default header bytes
//   DEF_TAIL       : default frame terminator byte
//   DEF_GAP_CYC    : default inter-byte timeout (1 ms at 50 MHz)
//   FRAME_LEN      : total bytes per frame (HDR0 HDR1 T3 T2 T1 T0 CTRL TAIL)
//   TIME_BYTES     : number of big-endian time bytes in a frame
// ---------------------------------------------------------------------------
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H1   = 3'd1,
        ST_TIME = 3'd2,
        ST_CTRL = 3'd3,
        ST_TAIL = 3'd4
    } frame_state_t;

    localparam logic [7:0]  DEF_HDR0    = 8'h55;
    localparam logic [7:0]  DEF_HDR1    = 8'hA5;
    localparam logic [7:0]  DEF_TAIL    = 8'hF0;
    localparam int unsigned DEF_GAP_CYC = 50000;

    localparam int unsigned FRAME_LEN   = 8;
    // Two header bytes, one control byte and one tail byte surround the time field.
    localparam int unsigned TIME_BYTES  = FRAME_LEN - 4;

endpackage

// File: rtl/frame_gap_timer.sv
// ---------------------------------------------------------------------------
// frame_gap_timer
// Inter-byte silence timer for the frame parser.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   clear   : restart the count (byte received, or parser idle)
//   enable  : count while a frame is in progress
//   expire  : high while the count sits at GAP_CYC-1 with no clear pending;
//             the parser acts on it at the following edge, so the abort lands
//             exactly GAP_CYC cycles after the last byte strobe
// ---------------------------------------------------------------------------
module frame_gap_timer #(
    parameter int unsigned GAP_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(GAP_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            // Saturate at LAST so a held-off parser never sees a wrapped count.
            count <= count + CW'(1);
        end
    end

    // A coincident clear (byte strobe) masks expiry: the byte wins.
    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl
// Parses 8-byte configuration frames from a UART byte receiver and commits
// an LED period and control byte on a well-formed frame.
// Frame: HDR0 HDR1 T3 T2 T1 T0 CTRL TAIL (time big-endian).
//   Clk        : system clock (50 MHz)
//   Reset      : synchronous active-high reset
//   rx_data    : received byte, valid while rx_done=1
//   rx_done    : one-cycle byte strobe
//   cfg_time   : committed LED period in Clk cycles
//   cfg_ctrl   : committed LED pattern/control byte
//   cfg_valid  : one-cycle pulse, one Clk after the tail strobe of a commit
//   frame_err  : one-cycle pulse on a rejected tail or inter-byte timeout
//   busy       : high whenever the parser is not idle
// ---------------------------------------------------------------------------
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HDR0    = DEF_HDR0,
    parameter logic [7:0]  HDR1    = DEF_HDR1,
    parameter logic [7:0]  TAIL    = DEF_TAIL,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [31:0] cfg_time,
    output logic [7:0]  cfg_ctrl,
    output logic        cfg_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [1:0] LAST_TIME_IDX = 2'(TIME_BYTES - 1);

    frame_state_t state;
    logic [1:0]   byte_cnt;
    logic [31:0]  shadow_time;
    logic [7:0]   shadow_ctrl;

    logic gap_clear;
    logic gap_enable;
    logic gap_expire;

    // The timer only runs mid-frame and restarts on every byte.
    assign gap_enable = (state != ST_IDLE);
    assign gap_clear  = rx_done || (state == ST_IDLE);

    frame_gap_timer #(
        .GAP_CYC (GAP_CYC)
    ) u_gap_timer (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (gap_clear),
        .enable (gap_enable),
        .expire (gap_expire)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            shadow_time <= '0;
            shadow_ctrl <= '0;
            cfg_time    <= '0;
            cfg_ctrl    <= '0;
            cfg_valid   <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;

            if (rx_done) begin
                unique case (state)
                    ST_IDLE: begin
                        if (rx_data == HDR0) begin
                            state <= ST_H1;
                            busy  <= 1'b1;
                        end
                    end

                    ST_H1: begin
                        if (rx_data == HDR1) begin
                            state    <= ST_TIME;
                            byte_cnt <= '0;
                        end else if (rx_data != HDR0) begin
                            // A repeated HDR0 keeps us here to resync.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    ST_TIME: begin
                        shadow_time <= {shadow_time[23:0], rx_data};
                        byte_cnt    <= byte_cnt + 2'd1;
                        if (byte_cnt == LAST_TIME_IDX) begin
                            state <= ST_CTRL;
                        end
                    end

                    ST_CTRL: begin
                        shadow_ctrl <= rx_data;
                        state       <= ST_TAIL;
                    end

                    ST_TAIL: begin
                        if ((rx_data == TAIL) && (shadow_time != '0)) begin
                            cfg_time  <= shadow_time;
                            cfg_ctrl  <= shadow_ctrl;
                            cfg_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (gap_expire) begin
                // Silence mid-frame: drop the partial frame, outputs hold.
                state     <= ST_IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule
